pulse_gen: RTL and testbench
============================

PULSE_GEN -- requirements
Module: pulse_gen

Interface
REQ-001 The block SHALL have parameter CH, default 4: number of independent channels.
REQ-002 The block SHALL have parameter CW, default 8: pulse-length counter width in bits.
REQ-003 The block SHALL have port clk, input, 1: rising-edge clock for all state.
REQ-004 The block SHALL have port rstn, input, 1: reset, asynchronous, active-low.
REQ-005 The block SHALL have port din, input, CH: per-channel level inputs.
REQ-006 The block SHALL have port mode, input, 2: trigger edge, common to all channels (00 falling, 01 rising, 10 both, 11 disabled).
REQ-007 The block SHALL have port len, input, CW: pulse length in clk cycles.
REQ-008 The block SHALL have port retrig, input, 1: when 1, an edge during a pulse restarts it.
REQ-009 The block SHALL have port clr, input, 1: synchronous clear of all ovf bits.
REQ-010 The block SHALL have port dout, output, CH: active-low pulse outputs, idle high.
REQ-011 The block SHALL have port busy, output, CH: 1 while the channel is in PULSE.
REQ-012 The block SHALL have port ovf, output, CH: sticky flag, set when a channel drops an edge.

Function
REQ-013 Each channel SHALL hold a registered previous input prev[i], updated from the input every cycle.
REQ-014 An edge on channel i SHALL be detected combinationally at clock edge k from prev[i] and the current input: falling {1,0}, rising {0,1}, both = either; mode 11 SHALL detect none.
REQ-015 Each channel SHALL run a 2-state FSM: IDLE (dout=1, busy=0) and PULSE (dout=0, busy=1).
REQ-016 IDLE->PULSE SHALL occur at the clock edge that detects the edge: dout falls one register delay after sampling, same timing as the existing single-cycle pulse block.
REQ-017 On entry to PULSE, cnt[i] SHALL load max(len,1); len == 0 SHALL be treated as 1.
REQ-018 len SHALL be sampled only at trigger or retrigger; len changes mid-pulse SHALL not affect the running pulse.
REQ-019 In PULSE without a retrigger, cnt SHALL decrement each cycle; when cnt == 1, the channel SHALL return to IDLE, giving exactly max(len,1) cycles of dout=0.
REQ-020 An edge in PULSE with retrig=1 SHALL reload cnt to max(len,1) and keep dout=0 without any high glitch.
REQ-021 An edge in PULSE with retrig=0 SHALL be ignored and SHALL set ovf[i].
REQ-022 An edge coinciding with the final count (cnt == 1) SHALL count as in-PULSE: retrig=1 extends the pulse; retrig=0 ends it and sets ovf.
REQ-023 ovf[i] SHALL stay set until clr=1; if clr and a new overflow occur in the same cycle, set SHALL win.
REQ-024 Channels SHALL be fully independent; simultaneous edges on all channels SHALL all be served in the same cycle.
REQ-025 All outputs SHALL be registered, with no combinational path from din to dout.

Reset
REQ-026 rstn=0 SHALL asynchronously force: every state to IDLE, dout all 1, busy all 0, ovf all 0, cnt all 0, prev all 1.
REQ-027 A reset asserted mid-pulse SHALL terminate the pulse immediately.
REQ-028 After reset release, a channel with din=0 and mode 00 or 10 SHALL fire on the first clock, because prev resets to 1.

Configuration
REQ-029 With macro PULSE_GEN_SYNC_EN defined, each din bit SHALL pass through a 2-flop synchronizer (reset value 1) before edge detection, adding exactly 2 cycles of latency.
REQ-030 Without PULSE_GEN_SYNC_EN, din SHALL feed edge detection directly and all timing SHALL be as stated above.

Verification
REQ-031 mode=00, len=3, din[0] 1->0 sampled at edge k -> dout[0]=0 for cycles k+1..k+3, busy[0]=1 over the same span, no ovf.
REQ-032 mode=01, len=0, din[2] 0->1 -> dout[2] low for exactly 1 cycle.
REQ-033 mode=10, len=5, retrig=1, second edge 2 cycles into the pulse -> total low time 7 cycles, ovf=0.
REQ-034 Same as REQ-033 with retrig=0 -> low time 5 cycles, ovf[i]=1 until clr is pulsed; clr and overflow in the same cycle -> ovf stays 1.
REQ-035 len=200, rstn pulsed low at cycle 50 of the pulse -> dout all 1, busy 0, ovf 0 asynchronously; mode=00 with din=0 at release -> fires on the first clock.
REQ-036 With PULSE_GEN_SYNC_EN defined, repeat REQ-031 -> dout[0] low for cycles k+3..k+5.

Source files
------------

// File: rtl/pulse_gen.sv
// Multi-channel edge-triggered pulse generator: active-low pulses of len cycles, optional retrigger, sticky overflow.
// Define PULSE_GEN_SYNC_EN to insert a 2-flop synchronizer (reset high) on every din bit.
module pulse_gen #(
    parameter int CH = 4,
    parameter int CW = 8
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic [CH-1:0] din,
    input  logic [1:0]    mode,
    input  logic [CW-1:0] len,
    input  logic          retrig,
    input  logic          clr,
    output logic [CH-1:0] dout,
    output logic [CH-1:0] busy,
    output logic [CH-1:0] ovf
);
    typedef enum logic {IDLE = 1'b0, PULSE = 1'b1} state_t;

    state_t        state_q [CH];
    state_t        state_d [CH];
    logic [CW-1:0] cnt_q [CH];
    logic [CW-1:0] cnt_d [CH];
    logic [CH-1:0] prev_q, prev_d;
    logic [CH-1:0] ovf_q, ovf_d;
    logic [CH-1:0] din_s;
    logic [CH-1:0] edge_det;
    logic [CW-1:0] len_eff;

`ifdef PULSE_GEN_SYNC_EN
    logic [CH-1:0] sync1_q, sync1_d;
    logic [CH-1:0] sync2_q, sync2_d;

    always_comb begin
        sync1_d = din;
        sync2_d = sync1_q;
    end

    // Resetting high keeps the synchronizer consistent with prev, so a low din still fires after release.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sync1_q <= '1;
            sync2_q <= '1;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
        end
    end

    assign din_s = sync2_q;
`else
    assign din_s = din;
`endif

    always_comb begin
        prev_d   = din_s;
        len_eff  = (len == '0) ? CW'(1) : len;
        edge_det = '0;
        case (mode)
            2'b00:   edge_det = prev_q & ~din_s;
            2'b01:   edge_det = ~prev_q & din_s;
            2'b10:   edge_det = prev_q ^ din_s;
            default: edge_det = '0;
        endcase
    end

    // An edge on the final count is still in-pulse: it either extends the pulse or only flags overflow.
    always_comb begin
        ovf_d = ovf_q & ~{CH{clr}};
        for (int i = 0; i < CH; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            if (state_q[i] == IDLE) begin
                if (edge_det[i]) begin
                    state_d[i] = PULSE;
                    cnt_d[i]   = len_eff;
                end
            end else begin
                if (edge_det[i] && retrig) begin
                    cnt_d[i] = len_eff;
                end else begin
                    if (edge_det[i]) begin
                        ovf_d[i] = 1'b1;
                    end
                    if (cnt_q[i] == CW'(1)) begin
                        state_d[i] = IDLE;
                        cnt_d[i]   = '0;
                    end else begin
                        cnt_d[i] = cnt_q[i] - CW'(1);
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            prev_q <= '1;
            ovf_q  <= '0;
            for (int i = 0; i < CH; i++) begin
                state_q[i] <= IDLE;
                cnt_q[i]   <= '0;
            end
        end else begin
            prev_q <= prev_d;
            ovf_q  <= ovf_d;
            for (int i = 0; i < CH; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
        end
    end

    always_comb begin
        for (int i = 0; i < CH; i++) begin
            dout[i] = (state_q[i] != PULSE);
            busy[i] = (state_q[i] == PULSE);
        end
    end

    assign ovf = ovf_q;

endmodule

// File: tb/tb_pulse_gen.sv
// Scoreboard bench for pulse_gen: an end-time reference model queues expected outputs per clock edge.
module tb_pulse_gen;
    localparam int CH = 4;
    localparam int CW = 8;
`ifdef PULSE_GEN_SYNC_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 0;
`endif

    logic          clk = 1'b0;
    logic          rstn;
    logic [CH-1:0] din;
    logic [1:0]    mode;
    logic [CW-1:0] len;
    logic          retrig;
    logic          clr;
    logic [CH-1:0] dout;
    logic [CH-1:0] busy;
    logic [CH-1:0] ovf;

    pulse_gen #(.CH(CH), .CW(CW)) dut (
        .clk    (clk),
        .rstn   (rstn),
        .din    (din),
        .mode   (mode),
        .len    (len),
        .retrig (retrig),
        .clr    (clr),
        .dout   (dout),
        .busy   (busy),
        .ovf    (ovf)
    );

    always #5 clk = ~clk;

    int              errors = 0;
    int              checks = 0;
    int              t = 0;
    logic [3*CH-1:0] expQ[$];
    logic [CH-1:0]   mPrev, mS1, mS2, mOvf;
    int              mEnd[CH];
    int              lowCount[CH];

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h (edge %0d)", tag, actual, expected, t);
        end
    endtask

    task automatic modelReset();
        mPrev = '1;
        mS1   = '1;
        mS2   = '1;
        mOvf  = '0;
        for (int i = 0; i < CH; i++) mEnd[i] = -10;
    endtask

    task automatic clearLow();
        for (int i = 0; i < CH; i++) lowCount[i] = 0;
    endtask

    // Pulse on channel i is low after edge u while u < mEnd[i]; an edge at u <= mEnd[i] is in-pulse.
    task automatic modelEdge();
        logic [CH-1:0] cur, det, expDout;
        int            l;
        logic          setOvf;
        cur = din;
`ifdef PULSE_GEN_SYNC_EN
        cur = mS2;
        mS2 = mS1;
        mS1 = din;
`endif
        case (mode)
            2'b00:   det = mPrev & ~cur;
            2'b01:   det = ~mPrev & cur;
            2'b10:   det = mPrev ^ cur;
            default: det = '0;
        endcase
        l = (len == 0) ? 1 : int'(len);
        for (int i = 0; i < CH; i++) begin
            setOvf = 1'b0;
            if (det[i]) begin
                if (!(t <= mEnd[i]) || retrig) mEnd[i] = t + l;
                else setOvf = 1'b1;
            end
            if (clr) mOvf[i] = 1'b0;
            if (setOvf) mOvf[i] = 1'b1;
            expDout[i] = !(t < mEnd[i]);
        end
        mPrev = cur;
        expQ.push_back({expDout, ~expDout, mOvf});
    endtask

    task automatic applyStimulus(input logic [CH-1:0] d, input logic [1:0] m, input logic [CW-1:0] l,
                                 input logic r, input logic c);
        logic [3*CH-1:0] e;
        din    = d;
        mode   = m;
        len    = l;
        retrig = r;
        clr    = c;
        modelEdge();
        @(posedge clk);
        #1;
        if (expQ.size() == 0) begin
            checkOutput("sbEmpty", 32'd1, 32'd0);
        end else begin
            e = expQ.pop_front();
            checkOutput("dout", dout, e[3*CH-1:2*CH]);
            checkOutput("busy", busy, e[2*CH-1:CH]);
            checkOutput("ovf", ovf, e[CH-1:0]);
        end
        for (int i = 0; i < CH; i++) if (dout[i] == 1'b0) lowCount[i]++;
        t++;
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rstn   = 1'b0;
        din    = '1;
        mode   = 2'b11;
        len    = '0;
        retrig = 1'b0;
        clr    = 1'b0;
        modelReset();
        clearLow();
        #2;
        checkOutput("rstDout", dout, 4'hF);
        checkOutput("rstBusy", busy, 4'h0);
        checkOutput("rstOvf", ovf, 4'h0);
        @(negedge clk);
        rstn = 1'b1;
        repeat (2) applyStimulus(4'hF, 2'b11, 8'd0, 1'b0, 1'b0);

        // Falling edge, len=3, len changed while the pulse runs
        repeat (2) applyStimulus(4'hF, 2'b00, 8'd3, 1'b0, 1'b0);
        clearLow();
        for (int j = 0; j <= LAT; j++) applyStimulus(4'hE, 2'b00, 8'd3, 1'b0, 1'b0);
        repeat (7) applyStimulus(4'hE, 2'b00, 8'd7, 1'b0, 1'b0);
        checkOutput("width031", lowCount[0], 3);
        checkOutput("ovf031", ovf[0], 1'b0);
        repeat (2 + LAT) applyStimulus(4'hF, 2'b00, 8'd3, 1'b0, 1'b0);

        // Rising edge with len=0 behaves as len=1
        repeat (3 + LAT) applyStimulus(4'hB, 2'b01, 8'd0, 1'b0, 1'b0);
        clearLow();
        repeat (4 + LAT) applyStimulus(4'hF, 2'b01, 8'd0, 1'b0, 1'b0);
        checkOutput("width032", lowCount[2], 1);

        // Both edges, retrigger two cycles into the pulse
        repeat (2 + LAT) applyStimulus(4'hF, 2'b10, 8'd5, 1'b1, 1'b0);
        clearLow();
        repeat (2) applyStimulus(4'hD, 2'b10, 8'd5, 1'b1, 1'b0);
        repeat (9 + LAT) applyStimulus(4'hF, 2'b10, 8'd5, 1'b1, 1'b0);
        checkOutput("width033", lowCount[1], 7);
        checkOutput("ovf033", ovf[1], 1'b0);

        // Same without retrigger: overflow, sticky, set wins over clr
        clearLow();
        repeat (2) applyStimulus(4'h7, 2'b10, 8'd5, 1'b0, 1'b0);
        repeat (8 + LAT) applyStimulus(4'hF, 2'b10, 8'd5, 1'b0, 1'b0);
        checkOutput("width034", lowCount[3], 5);
        checkOutput("ovf034", ovf[3], 1'b1);
        repeat (2) applyStimulus(4'h7, 2'b10, 8'd5, 1'b0, 1'b0);
        for (int j = 0; j <= LAT; j++) applyStimulus(4'hF, 2'b10, 8'd5, 1'b0, (j == LAT));
        checkOutput("ovfSetWins", ovf[3], 1'b1);
        repeat (5) applyStimulus(4'hF, 2'b10, 8'd5, 1'b0, 1'b0);
        applyStimulus(4'hF, 2'b10, 8'd5, 1'b0, 1'b1);
        checkOutput("ovfCleared", ovf[3], 1'b0);

        // All channels triggered together
        clearLow();
        repeat (5 + LAT) applyStimulus(4'h0, 2'b00, 8'd2, 1'b0, 1'b0);
        for (int i = 0; i < CH; i++) checkOutput($sformatf("widthAll%0d", i), lowCount[i], 2);

        // Disabled mode ignores edges, then a long pulse cut by async reset
        repeat (3 + LAT) applyStimulus(4'hF, 2'b11, 8'd200, 1'b0, 1'b0);
        repeat (50 + LAT) applyStimulus(4'hE, 2'b00, 8'd200, 1'b0, 1'b0);
        applyStimulus(4'hF, 2'b00, 8'd200, 1'b0, 1'b0);
        repeat (2 + LAT) applyStimulus(4'hE, 2'b00, 8'd200, 1'b0, 1'b0);
        checkOutput("ovfPreRst", ovf[0], 1'b1);
        checkOutput("busyPreRst", busy[0], 1'b1);
        #2;
        rstn = 1'b0;
        #1;
        checkOutput("asyncDout", dout, 4'hF);
        checkOutput("asyncBusy", busy, 4'h0);
        checkOutput("asyncOvf", ovf, 4'h0);
        modelReset();
        din  = 4'hE;
        mode = 2'b00;
        len  = 8'd2;
        @(negedge clk);
        rstn = 1'b1;
        for (int j = 0; j <= LAT; j++) applyStimulus(4'hE, 2'b00, 8'd2, 1'b0, 1'b0);
        checkOutput("fireAfterRst", busy[0], 1'b1);
        repeat (4) applyStimulus(4'hE, 2'b00, 8'd2, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
